// File: rtl/edge_event_detector.sv
// rtl/edge_event_detector.sv - multi-channel synchronise, debounce and edge-event detector
// Optional long-press detection: define EDGE_EVENT_LONG_PRESS_EN.
module edge_event_detector #(
  parameter int N               = 7,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] signal_in,
  input  logic [N-1:0] rise_en,
  input  logic [N-1:0] fall_en,
  input  logic [N-1:0] event_clear,
  output logic [N-1:0] stable_out,
  output logic [N-1:0] rise_pulse,
  output logic [N-1:0] fall_pulse,
  output logic [N-1:0] event_pending,
  output logic         irq,
  output logic [N-1:0] long_press
);

  localparam int CNT_W_RAW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (N < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 2) begin : g_param_check
    $error("edge_event_detector: illegal parameter value");
  end

  logic [N-1:0]     sync_q [SYNC_STAGES];
  logic [N-1:0]     s;
  logic [CNT_W-1:0] cnt_q  [N];
  logic [CNT_W-1:0] cnt_d  [N];
  logic [N-1:0]     stable_q, stable_d;
  logic [N-1:0]     rise_q, rise_d;
  logic [N-1:0]     fall_q, fall_d;
  logic [N-1:0]     pending_q, pending_d;
  logic             irq_q;

  // Plain flop chain per channel; no logic between stages so metastability can settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= signal_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce: a new level must persist DEBOUNCE_CYCLES cycles; acceptance produces the edge pulse.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = s[i];
          rise_d[i]   = s[i];
          fall_d[i]   = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // A new enabled edge beats a same-cycle clear so no event is lost.
    pending_d = (pending_q & ~event_clear) | (rise_d & rise_en) | (fall_d & fall_en);
  end

  // Debounce state, pulses, sticky flags and interrupt all update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
      irq_q     <= |pending_d;
    end
  end

  assign stable_out    = stable_q;
  assign rise_pulse    = rise_q;
  assign fall_pulse    = fall_q;
  assign event_pending = pending_q;
  assign irq           = irq_q;

`ifdef EDGE_EVENT_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q [N];
  logic [HOLD_W-1:0] hold_d [N];
  logic [N-1:0]      long_q, long_d;

  // Saturating hold counter; the pulse fires on the single step that reaches the threshold.
  always_comb begin
    long_d = '0;
    for (int i = 0; i < N; i++) begin
      hold_d[i] = '0;
      if (stable_q[i]) begin
        if (hold_q[i] != HOLD_MAX) begin
          hold_d[i] = hold_q[i] + 1'b1;
          long_d[i] = (hold_q[i] == HOLD_LAST);
        end else begin
          hold_d[i] = hold_q[i];
        end
      end
    end
  end

  // Hold counters and long-press pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) hold_q[i] <= '0;
      long_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) hold_q[i] <= hold_d[i];
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`else
  assign long_press = '0;
`endif

endmodule
